// File: rtl/jam_cost_table.sv
// Cost-matrix store for the job-assignment search: loads an NxN matrix row-major,
// then serves registered lookups. Optional per-row minimum / lower bound: JAM_COST_ROWMIN_EN.
module jam_cost_table #(
    parameter int N  = 8,
    parameter int CW = 7
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         InValid,
    input  logic [CW-1:0]                InData,
    output logic                         InReady,
    input  logic [$clog2(N)-1:0]         W,
    input  logic [$clog2(N)-1:0]         J,
    output logic [CW-1:0]                Cost,
    output logic                         TableReady,
    input  logic                         Release,
    output logic [$clog2(N*N+1)-1:0]     LoadCount,
    output logic [9:0]                   LowerBound
);
    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(N);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int LBW   = 10;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   cost_q;
    logic [CW-1:0]   mem [DEPTH];

    logic          beat;
    logic          last_beat;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign beat      = (state_q == LOAD) && InValid;
    assign last_beat = beat && (cnt_q == CNTW'(DEPTH - 1));
    assign wr_addr   = cnt_q[AW-1:0];
    assign rd_addr   = AW'(W) * AW'(N) + AW'(J);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (last_beat) state_d = HOLD;
                end
            end
            HOLD: begin
                if (Release) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cost_q  <= mem[rd_addr];
        end
    end

    // Storage has no reset so it maps onto block RAM; writes only happen in LOAD.
    always_ff @(posedge CLK) begin
        if (beat) mem[wr_addr] <= InData;
    end

    assign InReady    = (state_q == LOAD);
    assign TableReady = (state_q == HOLD);
    assign Cost       = cost_q;
    assign LoadCount  = cnt_q;

`ifdef JAM_COST_ROWMIN_EN
    logic [CW-1:0]  rowmin_q [N];
    logic [CW-1:0]  rowmin_d [N];
    logic [LBW-1:0] lb_q;
    logic [LBW-1:0] lb_sum;
    logic [IW-1:0]  wr_row;
    logic [IW-1:0]  wr_col;

    assign wr_row = wr_addr[AW-1:IW];
    assign wr_col = wr_addr[IW-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rowmin
            always_comb begin
                rowmin_d[gi] = rowmin_q[gi];
                if (beat && (wr_row == IW'(gi))) begin
                    if ((wr_col == '0) || (InData < rowmin_q[gi])) rowmin_d[gi] = InData;
                end
            end

            always_ff @(posedge CLK) begin
                rowmin_q[gi] <= rowmin_d[gi];
            end
        end
    endgenerate

    // Sum the next-state minima so the last row's final beat is included on entry to HOLD.
    always_comb begin
        lb_sum = '0;
        for (int i = 0; i < N; i++) lb_sum = lb_sum + LBW'(rowmin_d[i]);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lb_q <= '0;
        end else if (last_beat) begin
            lb_q <= lb_sum;
        end else if ((state_q == HOLD) && Release) begin
            lb_q <= '0;
        end
    end

    assign LowerBound = lb_q;
`else
    assign LowerBound = '0;
`endif

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream stage of the job-assignment search engine.
- Accepts an 8x8 worker/job cost matrix as a row-major stream over a valid/ready handshake, stores it, and then serves cost lookups to the search engine.
- The search engine presents W (worker row) and J (job column); this block returns Cost one cycle later.
- Raises TableReady once a full matrix is loaded and holds the table stable until the consumer releases it.

Parameters:
- N, 8, matrix dimension (workers = jobs = N); the index width is 3 at the default.
- CW, 7, cost entry width in bits.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, asynchronous, active-low (asserts on RST=0, independent of CLK).
- InValid  input  1  a load data beat is present.
- InData  input  CW  cost entry, row-major order: entry k maps to row k/N, column k%N.
- InReady  output  1  block accepts a beat this cycle.
- W  input  3  lookup row (worker).
- J  input  3  lookup column (job).
- Cost  output  CW  registered lookup result.
- TableReady  output  1  a complete matrix is held and lookups are valid.
- Release  input  1  one-cycle pulse from the consumer: search finished, the table may be reloaded.
- LoadCount  output  7  number of entries accepted in the current load (0..64).
- LowerBound  output  10  sum of the per-row minima (optional feature only).

Behaviour:
- Reset (RST=0), asynchronous, takes effect immediately:
  - state=IDLE; InReady=0, TableReady=0, Cost=0, LoadCount=0, LowerBound=0.
  - Storage contents are don't-care after reset.
- State machine:
  - IDLE: the next cycle goes to LOAD. InReady=0.
  - LOAD: InReady=1.
    - A beat transfers when InValid & InReady on a rising edge. The entry is written to index LoadCount and LoadCount increments.
    - On the transfer of the 64th beat (LoadCount 63->64), the next state is HOLD.
  - HOLD: InReady=0, TableReady=1.
    - Release=1 moves to IDLE and clears TableReady and LoadCount on that edge.
    - Reload therefore starts 2 cycles after Release.
- Lookup path: Cost <= mem[W*N+J] on every rising edge in every state. Latency is 1 cycle and is independent of TableReady.
  - Values returned while TableReady=0 are don't-care, but they must be a legal stored or reset value (no X after the first load).
- In LOAD, InValid=0 stalls the load with no side effects. InData is ignored when InValid=0.
- A beat offered while InReady=0 is not accepted, and the producer must hold it.
- Release outside HOLD is ignored.
- Simultaneous Release and InValid in HOLD: Release wins, and the beat is not accepted (InReady=0 in HOLD).
- W/J are 3-bit, so N=8 leaves no out-of-range index.
- No writes to storage occur in HOLD. The table is bit-stable for the whole search.
- If reset is asserted mid-load, the partial load is discarded. After reset release, a full 64-beat load is required again.

Optional Feature:
- Macro: JAM_COST_ROWMIN_EN.
- Defined:
  - One min register per row, CW bits.
  - When column 0 of a row is written, that row's min <= InData. For later columns, min <= min(min, InData).
  - On entry to HOLD, LowerBound <= sum of the 8 row minima (zero-extended to 10 bits; maximum 8*127=1016 fits).
  - LowerBound is stable while TableReady=1 and cleared on Release.
- Not defined:
  - No row-min logic is built.
  - LowerBound is tied to 0.

Test Plan:
- Reset/load: assert RST=0 mid-cycle, then release; stream 64 beats with InData=k%128 and InValid continuous.
  - InReady is high from the cycle after IDLE.
  - TableReady rises 1 cycle after the 64th transfer.
  - LoadCount reads 64.
- Lookup latency: after the load above, drive W=3, J=5 -> Cost=29 on the next edge. Then W=7, J=7 -> Cost=63.
- Backpressure/stall: toggle InValid every other cycle during a load -> exactly 64 transfers, and the matrix matches row-major order.
- Release/reload: pulse Release in HOLD with InValid=1 held.
  - That beat is not accepted.
  - TableReady falls on the Release edge; InReady returns 2 cycles later.
  - A second matrix, all entries 10, gives Cost=10 for any W/J.
- Reset mid-load: RST=0 after 20 beats -> LoadCount=0 and TableReady=0 immediately. The reload needs a full 64 beats.
- JAM_COST_ROWMIN_EN: load row r with values {r+1 at column r, 100 elsewhere} -> LowerBound = 1+2+...+8 = 36. Without the macro -> LowerBound=0.
